matrix_mult_param: RTL and testbench

Parametrised successor to the fixed 4x4 simple-memory matrix multiplier. Holds operand matrices A and B (NxN, DATA_W bits each) and result matrix C (NxN, ACC_W bits). All three are loadable or readable through a register-style port, and the block computes C = A*B or C += A*B on a start pulse.
One time-shared MAC executes per cycle. The block sits behind the system control bus as a small compute accelerator.

---
 rtl/matrix_mult_pkg.sv | 31 +++
 rtl/matrix_mult_param_mac.sv | 49 ++++
 rtl/matrix_mult_param.sv | 165 ++++++++++++++++
 tb/tb_matrix_mult_param.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared types and helpers for the parametrised matrix multiplier.
// Holds the FSM state encoding, default sizes and index arithmetic helpers.
package matrix_mult_pkg;

    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Width of a row-major element address for an n x n matrix.
    function automatic int addr_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    // Width of a single row/column/k counter for an n x n matrix.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Row-major flattening of (row, col) into an element index.
    function automatic int flat_index(input int n, input int row, input int col);
        return row * n + col;
    endfunction

endpackage

// File: rtl/matrix_mult_param_mac.sv
// Single time-shared multiply-accumulate stage.
// Multiplies two operands (signed or unsigned), extends the product to the
// accumulator width and adds it to either the running sum or a fresh start value.
module mac_unit
    import matrix_mult_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  init,
    output logic [ACC_W-1:0]  acc
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod_s;
    logic        [PW-1:0]    prod_u;
    logic signed [ACC_W-1:0] ext_s;
    logic        [ACC_W-1:0] ext_u;
    logic        [ACC_W-1:0] product;
    logic        [ACC_W-1:0] base;

    // Form the product in both interpretations and pick the extension that matches the mode.
    always_comb begin
        prod_s  = PW'($signed(a)) * PW'($signed(b));
        prod_u  = PW'(a) * PW'(b);
        ext_s   = ACC_W'(prod_s);
        ext_u   = ACC_W'(prod_u);
        product = signed_mode ? ext_s : ext_u;
        base    = load ? init : acc;
    end

    // Accumulate one product per enabled cycle; the sum wraps at the accumulator width.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= base + product;
        end
    end

endmodule

// File: rtl/matrix_mult_param.sv
// Parametrised N x N matrix multiplier with register-style operand/result access.
// Computes C = A*B or C += A*B using one shared MAC, one product per cycle,
// followed by one write-back cycle per result element.
module matrix_mult_param
    import matrix_mult_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    localparam int AW    = addr_width(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_mode,
    input  logic              accum_mode,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [ACC_W-1:0]  rd_data,
    output logic              busy,
    output logic              done
);

    localparam int IW    = index_width(N);
    localparam int DEPTH = N * N;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [ACC_W-1:0]  mem_c [DEPTH];

    state_t         state;
    logic [IW-1:0]  i_idx;
    logic [IW-1:0]  j_idx;
    logic [IW-1:0]  k_idx;
    logic           signed_lat;
    logic           accum_lat;

    logic [AW-1:0]     a_addr;
    logic [AW-1:0]     b_addr;
    logic [AW-1:0]     c_addr;
    logic [ACC_W-1:0]  acc_init;
    logic [ACC_W-1:0]  acc;
    logic              mac_en;
    logic              mac_load;

    // Element addresses for the current (i, k) operand, (k, j) operand and (i, j) result.
    always_comb begin
        a_addr   = AW'(flat_index(N, int'(i_idx), int'(k_idx)));
        b_addr   = AW'(flat_index(N, int'(k_idx), int'(j_idx)));
        c_addr   = AW'(flat_index(N, int'(i_idx), int'(j_idx)));
        acc_init = accum_lat ? mem_c[c_addr] : '0;
        mac_en   = (state == ST_MAC);
        mac_load = (k_idx == '0);
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk         (clk),
        .reset       (reset),
        .en          (mac_en),
        .load        (mac_load),
        .signed_mode (signed_lat),
        .a           (mem_a[a_addr]),
        .b           (mem_b[b_addr]),
        .init        (acc_init),
        .acc         (acc)
    );

    // Operand writes land only while idle so A and B stay frozen during a computation.
    always_ff @(posedge clk) begin
        if (!reset && state == ST_IDLE && wr_en) begin
            if (wr_sel) begin
                mem_b[wr_addr] <= wr_data;
            end else begin
                mem_a[wr_addr] <= wr_data;
            end
        end
    end

    // Finished accumulator is stored into C during the write-back cycle.
    always_ff @(posedge clk) begin
        if (!reset && state == ST_WRITE) begin
            mem_c[c_addr] <= acc;
        end
    end

    // Registered read port; returns C as it stood before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem_c[rd_addr];
        end
    end

    // Sequencer: walks k for each (i, j), writes back, and signals completion once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            i_idx      <= '0;
            j_idx      <= '0;
            k_idx      <= '0;
            signed_lat <= 1'b0;
            accum_lat  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= ST_MAC;
                        busy       <= 1'b1;
                        i_idx      <= '0;
                        j_idx      <= '0;
                        k_idx      <= '0;
                        signed_lat <= signed_mode;
                        accum_lat  <= accum_mode;
                    end
                end
                ST_MAC: begin
                    if (k_idx == LAST_IDX) begin
                        k_idx <= '0;
                        state <= ST_WRITE;
                    end else begin
                        k_idx <= k_idx + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (j_idx == LAST_IDX) begin
                        j_idx <= '0;
                        if (i_idx == LAST_IDX) begin
                            i_idx <= '0;
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            i_idx <= i_idx + 1'b1;
                            state <= ST_MAC;
                        end
                    end else begin
                        j_idx <= j_idx + 1'b1;
                        state <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_param.sv
// Self-checking bench for matrix_mult_param (N=4, DATA_W=8, ACC_W=20).
// Drives directed and random operand sets and compares C, timing and control
// outputs against an arithmetic reference model of the matrix product.
module tb_matrix_mult_param;

    localparam int N   = 4;
    localparam int NN  = N * N;
    localparam longint MASK = (64'd1 << 20) - 1;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic        accum_mode;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  rd_addr;
    logic [19:0] rd_data;
    logic        busy;
    logic        done;

    int     checks;
    int     failures;
    int     model_a [NN];
    int     model_b [NN];
    longint model_c [NN];

    int run_done_cycle;
    int run_busy_cycles;
    int run_done_count;
    int abort_done_count;

    matrix_mult_param dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .accum_mode  (accum_mode),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison point: counts it and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Write one operand element through the register port and mirror it in the model.
    task automatic applyStimulus(input bit sel, input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = 8'(data);
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) model_b[addr] = data & 255;
        else     model_a[addr] = data & 255;
    endtask

    function automatic longint as_value(input int v, input bit sm);
        if (sm && v >= 128) return longint'(v) - 256;
        return longint'(v);
    endfunction

    // Reference result: C = A*B (or C + A*B) reduced modulo 2^20.
    function automatic void computeModel(input bit sm, input bit am);
        longint tmp [NN];
        longint sum;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sum = am ? model_c[r*N+c] : 0;
                for (int k = 0; k < N; k++)
                    sum += as_value(model_a[r*N+k], sm) * as_value(model_b[k*N+c], sm);
                tmp[r*N+c] = sum & MASK;
            end
        end
        for (int e = 0; e < NN; e++) model_c[e] = tmp[e];
    endfunction

    // Read all of C back through the registered port and compare with the model.
    task automatic checkMatrix(input string tag);
        for (int e = 0; e < NN; e++) begin
            @(negedge clk);
            rd_addr = 4'(e);
            @(negedge clk);
            checkOutput($sformatf("%s_c%0d", tag, e), 64'(rd_data), 64'(model_c[e]));
        end
    endtask

    // Start a computation and watch it for a bounded number of cycles.
    // Optionally pokes start plus an A[0] write mid-run, or writes B[0] together with start.
    task automatic runCompute(input bit sm, input bit am, input int inject_at,
                              input bit co_wr, input int co_data,
                              output int done_cycle, output int busy_cycles, output int done_count);
        @(negedge clk);
        signed_mode = sm;
        accum_mode  = am;
        start       = 1'b1;
        if (co_wr) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b1;
            wr_addr = 4'd0;
            wr_data = 8'(co_data);
            model_b[0] = co_data & 255;
        end
        @(negedge clk);
        start       = 1'b0;
        wr_en       = 1'b0;
        signed_mode = ~sm;
        accum_mode  = ~am;
        done_cycle  = -1;
        busy_cycles = 0;
        done_count  = 0;
        for (int c = 1; c <= 90; c++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (c == inject_at) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 4'd0;
                wr_data = 8'h55;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic checkTiming(input string tag);
        checkOutput({tag, "_done_cycle"}, 64'(run_done_cycle), 64'd81);
        checkOutput({tag, "_busy_cycles"}, 64'(run_busy_cycles), 64'd80);
        checkOutput({tag, "_done_pulses"}, 64'(run_done_count), 64'd1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        accum_mode  = 1'b0;
        wr_en       = 1'b0;
        wr_sel      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_addr     = '0;
        for (int e = 0; e < NN; e++) begin
            model_a[e] = 0;
            model_b[e] = 0;
            model_c[e] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
        reset = 1'b0;

        // Identity A with B[e] = e+1, unsigned, overwrite
        $display("[TB] identity");
        for (int e = 0; e < NN; e++) applyStimulus(1'b0, e, (e / N == e % N) ? 1 : 0);
        for (int e = 0; e < NN; e++) applyStimulus(1'b1, e, e + 1);
        runCompute(1'b0, 1'b0, 0, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b0, 1'b0);
        checkTiming("ident");
        checkMatrix("ident");

        // All-ones-byte times two, signed then unsigned
        $display("[TB] signed/unsigned");
        for (int e = 0; e < NN; e++) applyStimulus(1'b0, e, 8'hFF);
        for (int e = 0; e < NN; e++) applyStimulus(1'b1, e, 8'h02);
        runCompute(1'b1, 1'b0, 0, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b1, 1'b0);
        checkTiming("signed");
        checkOutput("signed_model_c0", 64'(model_c[0]), 64'h0FFFF8);
        checkMatrix("signed");
        runCompute(1'b0, 1'b0, 0, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b0, 1'b0);
        checkMatrix("unsigned");

        // Accumulate: overwrite, accumulate, overwrite
        $display("[TB] accumulate");
        for (int e = 0; e < NN; e++) applyStimulus(1'b0, e, e + 1);
        for (int e = 0; e < NN; e++) applyStimulus(1'b1, e, (e / N == e % N) ? 1 : 0);
        runCompute(1'b0, 1'b0, 0, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b0, 1'b0);
        checkMatrix("acc_first");
        runCompute(1'b0, 1'b1, 0, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b0, 1'b1);
        checkTiming("acc_second");
        checkMatrix("acc_second");
        runCompute(1'b0, 1'b0, 0, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b0, 1'b0);
        checkMatrix("acc_third");

        // Start and write while busy are ignored
        $display("[TB] busy poke");
        for (int e = 0; e < NN; e++) applyStimulus(1'b0, e, $urandom_range(0, 255));
        for (int e = 0; e < NN; e++) applyStimulus(1'b1, e, $urandom_range(0, 255));
        runCompute(1'b0, 1'b0, 20, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b0, 1'b0);
        checkTiming("poke");
        checkMatrix("poke");
        runCompute(1'b0, 1'b0, 0, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b0, 1'b0);
        checkMatrix("poke_rerun");

        // Reset in the middle of a run
        $display("[TB] reset mid-run");
        @(negedge clk);
        signed_mode = 1'b1;
        accum_mode  = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_rd_data", 64'(rd_data), 64'd0);
        reset = 1'b0;
        abort_done_count = 0;
        for (int c = 0; c < 100; c++) begin
            if (done) abort_done_count++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 64'(abort_done_count), 64'd0);
        runCompute(1'b1, 1'b0, 0, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b1, 1'b0);
        checkTiming("after_abort");
        checkMatrix("after_abort");

        // Write B[0] in the same cycle as start
        $display("[TB] write with start");
        for (int e = 0; e < NN; e++) applyStimulus(1'b0, e, (e / N == e % N) ? 1 : 0);
        runCompute(1'b0, 1'b0, 0, 1'b1, 7, run_done_cycle, run_busy_cycles, run_done_count);
        computeModel(1'b0, 1'b0);
        checkOutput("cowrite_model_c0", 64'(model_c[0]), 64'd7);
        checkMatrix("cowrite");

        // Random operands and modes
        $display("[TB] random");
        for (int t = 0; t < 3; t++) begin
            bit rs;
            bit ra;
            rs = 1'($urandom_range(0, 1));
            ra = 1'($urandom_range(0, 1));
            for (int e = 0; e < NN; e++) applyStimulus(1'b0, e, $urandom_range(0, 255));
            for (int e = 0; e < NN; e++) applyStimulus(1'b1, e, $urandom_range(0, 255));
            runCompute(rs, ra, 0, 1'b0, 0, run_done_cycle, run_busy_cycles, run_done_count);
            computeModel(rs, ra);
            checkTiming($sformatf("rand%0d", t));
            checkMatrix($sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
